// File: rtl/mmio_dmem_if.sv
// Core load/store port plus console drain handshake for mmio_dmem.
// The master side is the core/console pair; the slave side is the responder.
interface mmio_dmem_if;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [31:0] cons_data;
  logic        cons_valid;
  logic        cons_ready;
  logic        halt;
  logic        overflow;

  modport master (
    output we, a, wd, cons_ready,
    input  rd, cons_data, cons_valid, halt, overflow
  );

  modport slave (
    input  we, a, wd, cons_ready,
    output rd, cons_data, cons_valid, halt, overflow
  );
endinterface

// File: rtl/mmio_dmem.sv
// Data memory with console FIFO at word 0 and halt/status at word 1; combinational reads, stores on edge.
// Console words are visible one edge after the store; a full FIFO drops the push (sticky overflow) unless it pops that cycle.
module mmio_dmem #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  mmio_dmem_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int AW    = $clog2(RAM_WORDS);

  logic [29:0]      idx;
  logic             is_cons;
  logic             is_stat;
  logic             is_ram;
  logic [AW-1:0]    ram_addr;

  logic [31:0]      ram_q  [RAM_WORDS];
  logic [31:0]      fifo_q [FIFO_DEPTH];

  logic [PTR_W-1:0] wrptr_q, wrptr_d;
  logic [PTR_W-1:0] rdptr_q, rdptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             halt_q, halt_d;
  logic             overflow_q, overflow_d;

  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             fifo_full;
  logic             unused_byte_sel;

  assign idx             = bus.a[31:2];
  assign unused_byte_sel = ^bus.a[1:0];
  assign ram_addr        = idx[AW-1:0];

  assign is_cons = (idx == 30'd0);
  assign is_stat = (idx == 30'd1);
  assign is_ram  = (idx >= 30'd2) && (idx < 30'(RAM_WORDS));

  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop       = (count_q != '0) && bus.cons_ready;
  assign push_req  = bus.we && is_cons;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign push_ok   = push_req && (!fifo_full || pop);

  always_comb begin
    wrptr_d    = wrptr_q;
    rdptr_d    = rdptr_q;
    count_d    = count_q;
    halt_d     = halt_q;
    overflow_d = overflow_q;

    if (push_ok) begin
      wrptr_d = wrptr_q + PTR_W'(1);
    end
    if (pop) begin
      rdptr_d = rdptr_q + PTR_W'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end

    if (bus.we && is_stat) begin
      halt_d = 1'b1;
    end
    if (push_req && !push_ok) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrptr_q    <= '0;
      rdptr_q    <= '0;
      count_q    <= '0;
      halt_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wrptr_q    <= wrptr_d;
      rdptr_q    <= rdptr_d;
      count_q    <= count_d;
      halt_q     <= halt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage arrays are deliberately not reset; RAM contents survive a reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_q[wrptr_q] <= bus.wd;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.we && is_ram) begin
      ram_q[ram_addr] <= bus.wd;
    end
  end

  always_comb begin
    bus.rd = 32'd0;
    if (is_cons) begin
      bus.rd = 32'(count_q);
    end else if (is_stat) begin
      bus.rd = {30'd0, overflow_q, halt_q};
    end else if (is_ram) begin
      bus.rd = ram_q[ram_addr];
    end
  end

  assign bus.cons_data  = fifo_q[rdptr_q];
  assign bus.cons_valid = (count_q != '0);
  assign bus.halt       = halt_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_mmio_dmem.sv
// Directed bench for mmio_dmem: reset, console FIFO ordering/overflow/full push+pop, RAM decode, halt, async reset.
module tb_mmio_dmem;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  mmio_dmem_if bus();

  mmio_dmem #(.RAM_WORDS(64), .FIFO_DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.we = 1'b1;
    bus.a  = addr;
    bus.wd = data;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.a = 32'd0;
    #1;
    vectors++;
    if (bus.rd !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_rd0: got %h expected %h", bus.rd, 32'd0);
    end
    bus.a = 32'd4;
    #1;
    vectors++;
    if (bus.rd !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_rd4: got %h expected %h", bus.rd, 32'd0);
    end
    vectors++;
    if ({bus.cons_valid, bus.halt, bus.overflow} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 000", {bus.cons_valid, bus.halt, bus.overflow});
    end
  endtask

  task automatic test_fifo_basic();
    logic [31:0] exp_vals [3];
    exp_vals[0] = 32'd11;
    exp_vals[1] = 32'd22;
    exp_vals[2] = 32'd33;
    bus.cons_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_store(32'd0, exp_vals[i]);
    bus.a = 32'd0;
    #1;
    vectors++;
    if (bus.rd !== 32'd3) begin
      miscompares++;
      $display("FAIL basic_count: got %0d expected 3", bus.rd);
    end
    bus.cons_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (bus.cons_valid !== 1'b1 || bus.cons_data !== exp_vals[i]) begin
        miscompares++;
        $display("FAIL basic_drain%0d: got v=%b d=%0d expected v=1 d=%0d",
                 i, bus.cons_valid, bus.cons_data, exp_vals[i]);
      end
      @(posedge clk);
      #1;
    end
    bus.cons_ready = 1'b0;
    vectors++;
    if (bus.cons_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_empty: got cons_valid=%b expected 0", bus.cons_valid);
    end
    #1;
    vectors++;
    if (bus.rd !== 32'd0) begin
      miscompares++;
      $display("FAIL basic_count0: got %0d expected 0", bus.rd);
    end
  endtask

  task automatic test_overflow();
    bus.cons_ready = 1'b0;
    for (int i = 1; i <= 9; i++) do_store(32'd0, 32'(i));
    bus.a = 32'd0;
    #1;
    vectors++;
    if (bus.rd !== 32'd8) begin
      miscompares++;
      $display("FAIL ovf_count: got %0d expected 8", bus.rd);
    end
    vectors++;
    if (bus.overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_flag: got %b expected 1", bus.overflow);
    end
    bus.cons_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      vectors++;
      if (bus.cons_valid !== 1'b1 || bus.cons_data !== 32'(i)) begin
        miscompares++;
        $display("FAIL ovf_drain%0d: got v=%b d=%0d expected v=1 d=%0d",
                 i, bus.cons_valid, bus.cons_data, i);
      end
      @(posedge clk);
      #1;
    end
    bus.cons_ready = 1'b0;
    vectors++;
    if (bus.cons_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_empty: got cons_valid=%b (d=%0d) expected 0", bus.cons_valid, bus.cons_data);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    bus.cons_ready = 1'b0;
    for (int i = 0; i < 8; i++) do_store(32'd0, 32'd100 + 32'(i));
    @(negedge clk);
    bus.we = 1'b1;
    bus.a  = 32'd0;
    bus.wd = 32'h0000ABCD;
    bus.cons_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    bus.cons_ready = 1'b0;
    #1;
    vectors++;
    if (bus.rd !== 32'd8) begin
      miscompares++;
      $display("FAIL full_count: got %0d expected 8", bus.rd);
    end
    vectors++;
    if (bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL full_ovf: got %b expected 0", bus.overflow);
    end
    bus.cons_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      logic [31:0] exp_d;
      exp_d = (i == 8) ? 32'h0000ABCD : 32'd100 + 32'(i);
      #1;
      vectors++;
      if (bus.cons_valid !== 1'b1 || bus.cons_data !== exp_d) begin
        miscompares++;
        $display("FAIL full_drain%0d: got v=%b d=%h expected v=1 d=%h",
                 i, bus.cons_valid, bus.cons_data, exp_d);
      end
      @(posedge clk);
      #1;
    end
    bus.cons_ready = 1'b0;
    vectors++;
    if (bus.cons_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_empty: got cons_valid=%b expected 0", bus.cons_valid);
    end
  endtask

  task automatic test_ram_and_halt();
    do_store(32'd8, 32'h12345678);
    bus.a = 32'd8;
    #1;
    vectors++;
    if (bus.rd !== 32'h12345678) begin
      miscompares++;
      $display("FAIL ram_rd8: got %h expected %h", bus.rd, 32'h12345678);
    end
    bus.a = 32'd11;
    #1;
    vectors++;
    if (bus.rd !== 32'h12345678) begin
      miscompares++;
      $display("FAIL ram_bytesel: got %h expected %h", bus.rd, 32'h12345678);
    end
    do_store(32'd252, 32'hCAFEF00D);
    bus.a = 32'd252;
    #1;
    vectors++;
    if (bus.rd !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL ram_last: got %h expected %h", bus.rd, 32'hCAFEF00D);
    end
    do_store(32'd256, 32'hDEADBEEF);
    bus.a = 32'd256;
    #1;
    vectors++;
    if (bus.rd !== 32'd0) begin
      miscompares++;
      $display("FAIL ram_oob: got %h expected %h", bus.rd, 32'd0);
    end
    bus.a = 32'd8;
    #1;
    vectors++;
    if (bus.rd !== 32'h12345678) begin
      miscompares++;
      $display("FAIL ram_oob_alias: got %h expected %h", bus.rd, 32'h12345678);
    end
    do_store(32'd4, 32'd0);
    vectors++;
    if (bus.halt !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_flag: got %b expected 1", bus.halt);
    end
    bus.a = 32'd4;
    #1;
    vectors++;
    if (bus.rd !== 32'd1) begin
      miscompares++;
      $display("FAIL halt_rd: got %h expected %h", bus.rd, 32'd1);
    end
    do_store(32'd0, 32'd55);
    #1;
    vectors++;
    if (bus.cons_valid !== 1'b1 || bus.cons_data !== 32'd55 || bus.halt !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_push: got v=%b d=%0d h=%b expected v=1 d=55 h=1",
               bus.cons_valid, bus.cons_data, bus.halt);
    end
  endtask

  task automatic test_async_reset();
    do_store(32'd0, 32'd66);
    do_store(32'd0, 32'd77);
    bus.a = 32'd0;
    #1;
    vectors++;
    if (bus.rd !== 32'd3) begin
      miscompares++;
      $display("FAIL arst_pre_count: got %0d expected 3", bus.rd);
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.cons_valid !== 1'b0 || bus.halt !== 1'b0 || bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_flags: got v=%b h=%b o=%b expected 0 0 0",
               bus.cons_valid, bus.halt, bus.overflow);
    end
    bus.a = 32'd8;
    #1;
    vectors++;
    if (bus.rd !== 32'h12345678) begin
      miscompares++;
      $display("FAIL arst_ram: got %h expected %h", bus.rd, 32'h12345678);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    bus.a = 32'd0;
    #1;
    vectors++;
    if (bus.rd !== 32'd0 || bus.cons_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_post: got count=%0d v=%b expected 0 0", bus.rd, bus.cons_valid);
    end
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b1;
    bus.we         = 1'b0;
    bus.a          = 32'd0;
    bus.wd         = 32'd0;
    bus.cons_ready = 1'b0;

    test_reset();
    test_fifo_basic();
    test_overflow();
    test_full_push_pop();
    test_ram_and_halt();
    test_async_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmio_dmem.md
Name: mmio_dmem

Overview:
- Data-memory responder for the single-cycle core's load/store port. It replaces plain word RAM with an address-decoded responder.
- Word 0 is a console output port backed by a FIFO, which a downstream console/monitor drains over a valid/ready handshake.
- Word 1 is a halt/status register.
- Words 2 and up are ordinary RAM.
- The core side matches the existing dmem contract: combinational read, write on the rising clock edge when we is high.

Parameters:
- RAM_WORDS, 64, number of 32-bit words decoded, including the two MMIO words; must be ≥ 3.
- FIFO_DEPTH, 8, console FIFO entries; power of two, ≥ 2.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of the FIFO occupancy count.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- we  input  1  store strobe from core (memwrite).
- a  input  32  byte address from core (aluout); only a[31:2] is decoded, a[1:0] ignored.
- wd  input  32  store data from core (writedata).
- rd  output  32  load data to core (readdata); combinational.
- cons_data  output  32  FIFO head word.
- cons_valid  output  1  FIFO non-empty.
- cons_ready  input  1  consumer accepts head this cycle.
- halt  output  1  sticky halt flag.
- overflow  output  1  sticky flag: a console push was dropped.

Behaviour:
- Reset (asynchronous, active-high):
  - Clears FIFO read/write pointers, count, halt and overflow.
  - cons_valid=0 and halt=0 immediately.
  - cons_data is don't-care while cons_valid=0.
  - RAM contents are NOT cleared. Reset mid-operation discards all queued console words.
- Word index idx = a[31:2].
- Writes, taking effect on the rising edge when we=1:
  - idx=0: push wd into the console FIFO.
  - idx=1: set halt=1; the value of wd is ignored.
  - 2 ≤ idx < RAM_WORDS: RAM[idx] <= wd.
  - idx ≥ RAM_WORDS: write ignored, no other effect.
- Reads (combinational, no latency; rd depends on the current a and registered state only):
  - idx=0: rd = {(32-CNT_W) zeros, count}.
  - idx=1: rd = {30'b0, overflow, halt}.
  - 2 ≤ idx < RAM_WORDS: rd = RAM[idx].
  - idx ≥ RAM_WORDS: rd = 0.
  - Reading word 0 does not pop the FIFO.
- FIFO pop:
  - pop = cons_valid & cons_ready; it advances the read pointer on the edge.
  - cons_valid = (count != 0).
  - cons_data = storage[rdptr], combinational from registered state.
- FIFO push:
  - push_req = we & (idx==0).
  - A push is accepted if count < FIFO_DEPTH, or if pop occurs in the same cycle (full + simultaneous push and pop is accepted; count stays FIFO_DEPTH).
  - A push_req that is not accepted is dropped: storage and pointers are unchanged and overflow is set to 1.
- Count update:
  - +1 on accepted push without pop.
  - −1 on pop without push.
  - Unchanged on both or neither.
- Empty with simultaneous push and pop: pop cannot occur (cons_valid=0); the push is accepted and cons_valid rises after that edge.
- Latency:
  - A word pushed at edge N appears on cons_data/cons_valid after edge N, provided it is at the head.
  - Ordering is strict FIFO.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH with no gap.
- halt and overflow are sticky until reset.
- Pushes after halt are still accepted (they drain the final output).
- The consumer may deassert cons_ready at any time; cons_data is held stable while cons_valid=1 and no pop occurs.
- No X may propagate to cons_valid, halt or overflow after reset.

Test Plan:
- Reset, then read a=0 and a=4 → rd=0 for both; cons_valid=0, halt=0, overflow=0.
- With cons_ready=0, store 11, 22, 33 to a=0 on three cycles → read a=0 returns 3. Then cons_ready=1 → cons_data is 11, 22, 33 on consecutive cycles; cons_valid drops after the third pop; read a=0 returns 0.
- With cons_ready=0, store 1..9 to a=0 → count 8, overflow=1 after the 9th edge. Drain yields 1..8; the value 9 is never seen.
- FIFO full (8 entries), single cycle with we=1, a=0, wd=0xABCD and cons_ready=1 → head pops, 0xABCD is accepted, count stays 8, overflow stays 0, 0xABCD emerges last.
- Store 0x12345678 to a=8 → read a=8 returns 0x12345678 in the same cycle after the edge. Store to a=RAM_WORDS*4 → read of that address returns 0 and RAM word 2 is unchanged. Store to a=4 → halt=1; read a=4 returns 1.
- With 3 words queued and RAM[2] written, assert reset asynchronously between clock edges → cons_valid=0 and halt=0 immediately; read a=8 still returns the stored value.
